// File: rtl/if_fetch_predict_if.sv
// if_fetch_predict_if: hazard, branch-resolution, imem and IF/ID signals of the fetch stage.
interface if_fetch_predict_if #(
    parameter int DBITS          = 32,
    parameter int IMEM_ADDR_BITS = 11
);
    logic                      stall;
    logic                      mispredict;
    logic [DBITS-1:0]          correctPC;
    logic                      exUpdate;
    logic [DBITS-1:0]          exPC;
    logic                      exTaken;
    logic [IMEM_ADDR_BITS-1:0] imemAddr;
    logic [DBITS-1:0]          imemData;
    logic [DBITS-1:0]          pc;
    logic [DBITS-1:0]          pcIncremented;
    logic [DBITS-1:0]          instWord;
    logic [DBITS-1:0]          brBaseOffset;
    logic                      prediction;
    logic                      ifWrtEn;
    logic                      ifFlush;

    modport master (
        output stall, mispredict, correctPC, exUpdate, exPC, exTaken, imemData,
        input  imemAddr, pc, pcIncremented, instWord, brBaseOffset, prediction, ifWrtEn, ifFlush
    );

    modport slave (
        input  stall, mispredict, correctPC, exUpdate, exPC, exTaken, imemData,
        output imemAddr, pc, pcIncremented, instWord, brBaseOffset, prediction, ifWrtEn, ifFlush
    );
endinterface

// File: rtl/if_fetch_predict.sv
// if_fetch_predict: PC register, imem fetch, 2-bit-counter branch prediction and target computation.
module if_fetch_predict #(
    parameter int               DBITS          = 32,
    parameter int               IMEM_ADDR_BITS = 11,
    parameter int               BHT_INDEX_BITS = 6,
    parameter logic [DBITS-1:0] START_PC       = 'h40,
    parameter logic [3:0]       BR_OP          = 4'b0110
) (
    input logic              clk,
    input logic              reset,
    if_fetch_predict_if.slave bus
);
    localparam int BHT_SIZE = 2 ** BHT_INDEX_BITS;

    logic [DBITS-1:0]          pc_q, pc_d;
    logic [1:0]                bht_q [BHT_SIZE];
    logic [1:0]                bht_d [BHT_SIZE];
    logic [DBITS-1:0]          pc_inc, br_target, imm_ext;
    logic                      is_branch, predict;
    logic [BHT_INDEX_BITS-1:0] look_idx, upd_idx;
    logic [1:0]                upd_cnt, upd_nxt;

    assign pc_inc    = pc_q + DBITS'(4);
    assign imm_ext   = {{(DBITS-18){bus.imemData[15]}}, bus.imemData[15:0], 2'b00};
    assign br_target = pc_inc + imm_ext;
    assign is_branch = bus.imemData[31:28] == BR_OP;
    assign look_idx  = pc_q[BHT_INDEX_BITS+1:2];
    assign predict   = is_branch & bht_q[look_idx][1];

    assign bus.imemAddr      = pc_q[IMEM_ADDR_BITS+1:2];
    assign bus.pc            = pc_q;
    assign bus.pcIncremented = pc_inc;
    assign bus.instWord      = bus.imemData;
    assign bus.brBaseOffset  = br_target;
    assign bus.prediction    = predict;
    assign bus.ifWrtEn       = ~bus.stall | bus.mispredict;
    assign bus.ifFlush       = reset | bus.mispredict;

    assign pc_d = bus.mispredict ? bus.correctPC :
                  bus.stall      ? pc_q          :
                  predict        ? br_target     : pc_inc;

    // Training writes the registered table only; a same-cycle lookup sees the old counter.
    always_comb begin
        bht_d   = bht_q;
        upd_idx = bus.exPC[BHT_INDEX_BITS+1:2];
        upd_cnt = bht_q[upd_idx];
        upd_nxt = bus.exTaken ? ((upd_cnt == 2'b11) ? 2'b11 : upd_cnt + 2'b01)
                              : ((upd_cnt == 2'b00) ? 2'b00 : upd_cnt - 2'b01);
        bht_d[upd_idx] = bus.exUpdate ? upd_nxt : upd_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= START_PC;
            for (int i = 0; i < BHT_SIZE; i++) bht_q[i] <= 2'b01;
        end else begin
            pc_q  <= pc_d;
            bht_q <= bht_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_predict.sv
// tb_if_fetch_predict: scenario tasks with a queue of expected next-PC values.
module tb_if_fetch_predict;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] BR_NEG = 32'h6000_FFFE;
    localparam logic [31:0] BR_ONE = 32'h6000_0001;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    if_fetch_predict_if bus ();
    if_fetch_predict dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.stall = 0; bus.mispredict = 0; bus.correctPC = 0;
        bus.exUpdate = 0; bus.exPC = 0; bus.exTaken = 0;
    endtask

    task automatic redirect(input logic [31:0] a);
        bus.imemData = NOP; bus.mispredict = 1; bus.correctPC = a;
        tick();
        bus.mispredict = 0;
        #1;
    endtask

    task automatic train(input logic taken);
        bus.imemData = NOP; bus.mispredict = 1; bus.correctPC = 32'h60;
        bus.exUpdate = 1; bus.exPC = 32'h60; bus.exTaken = taken;
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset;
        idle(); reset = 1; bus.imemData = NOP;
        tick(); tick();
        total_cnt++;
        if (bus.ifFlush !== 1'b1) $display("FAIL reset_flush got=%0b want=1", bus.ifFlush); else pass_cnt++;
        reset = 0; #1;
        total_cnt++;
        if (bus.pc !== 32'h40) $display("FAIL reset_pc got=%h want=00000040", bus.pc); else pass_cnt++;
        total_cnt++;
        if (bus.imemAddr !== 11'd16) $display("FAIL reset_imemaddr got=%0d want=16", bus.imemAddr); else pass_cnt++;
        total_cnt++;
        if (bus.ifWrtEn !== 1'b1 || bus.ifFlush !== 1'b0)
            $display("FAIL reset_wrt_flush got=%0b%0b want=10", bus.ifWrtEn, bus.ifFlush); else pass_cnt++;
        total_cnt++;
        if (bus.pcIncremented !== 32'h44) $display("FAIL reset_pcinc got=%h want=00000044", bus.pcIncremented); else pass_cnt++;
        exp_q.push_back(32'h44); exp_q.push_back(32'h48); exp_q.push_back(32'h4C);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (bus.pc !== exp_v) $display("FAIL seq_pc%0d got=%h want=%h", i, bus.pc, exp_v); else pass_cnt++;
        end
    endtask

    task automatic test_stall;
        redirect(32'h48);
        bus.stall = 1; #1;
        total_cnt++;
        if (bus.ifWrtEn !== 1'b0) $display("FAIL stall_wrten got=%0b want=0", bus.ifWrtEn); else pass_cnt++;
        exp_q.push_back(32'h48); exp_q.push_back(32'h48);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (bus.pc !== exp_v) $display("FAIL stall_hold%0d got=%h want=%h", i, bus.pc, exp_v); else pass_cnt++;
        end
        bus.stall = 0;
        exp_q.push_back(32'h4C);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.pc !== exp_v) $display("FAIL stall_release got=%h want=%h", bus.pc, exp_v); else pass_cnt++;
        bus.stall = 1; bus.mispredict = 1; bus.correctPC = 32'h100; #1;
        total_cnt++;
        if (bus.ifWrtEn !== 1'b1 || bus.ifFlush !== 1'b1)
            $display("FAIL mispred_wrt_flush got=%0b%0b want=11", bus.ifWrtEn, bus.ifFlush); else pass_cnt++;
        exp_q.push_back(32'h100);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.pc !== exp_v) $display("FAIL mispred_pc got=%h want=%h", bus.pc, exp_v); else pass_cnt++;
        idle();
    endtask

    task automatic test_predict_default;
        redirect(32'h60);
        bus.imemData = BR_NEG; #1;
        total_cnt++;
        if (bus.prediction !== 1'b0) $display("FAIL dflt_pred got=%0b want=0", bus.prediction); else pass_cnt++;
        total_cnt++;
        if (bus.brBaseOffset !== 32'h5C) $display("FAIL dflt_target got=%h want=0000005c", bus.brBaseOffset); else pass_cnt++;
        total_cnt++;
        if (bus.instWord !== BR_NEG) $display("FAIL dflt_inst got=%h want=%h", bus.instWord, BR_NEG); else pass_cnt++;
        exp_q.push_back(32'h64);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.pc !== exp_v) $display("FAIL dflt_next got=%h want=%h", bus.pc, exp_v); else pass_cnt++;
    endtask

    task automatic test_training;
        logic exp_pred [6];
        logic tk [7];
        // counter path from 01: T,T ->11 | T(sat) NT ->10 | NT ->01 | NT ->00 | NT(sat) T ->01
        tk = '{1, 1, 1, 0, 0, 0, 0};
        train(tk[0]); train(tk[1]);
        bus.imemData = BR_NEG; #1;
        total_cnt++;
        if (bus.prediction !== 1'b1) $display("FAIL train_11_pred got=%0b want=1", bus.prediction); else pass_cnt++;
        exp_q.push_back(32'h5C);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.pc !== exp_v) $display("FAIL train_taken_pc got=%h want=%h", bus.pc, exp_v); else pass_cnt++;
        exp_pred = '{1, 0, 0, 0, 0, 0};
        train(tk[2]); train(tk[3]);
        bus.imemData = BR_NEG; #1;
        total_cnt++;
        if (bus.prediction !== exp_pred[0]) $display("FAIL train_sat_hi got=%0b want=%0b", bus.prediction, exp_pred[0]); else pass_cnt++;
        for (int i = 1; i < 3; i++) begin
            train(1'b0);
            bus.imemData = BR_NEG; #1;
            total_cnt++;
            if (bus.prediction !== exp_pred[i]) $display("FAIL train_nt%0d got=%0b want=%0b", i, bus.prediction, exp_pred[i]); else pass_cnt++;
        end
        train(1'b0); train(1'b1);
        bus.imemData = BR_NEG; #1;
        total_cnt++;
        if (bus.prediction !== exp_pred[3]) $display("FAIL train_sat_lo got=%0b want=%0b", bus.prediction, exp_pred[3]); else pass_cnt++;
    endtask

    task automatic test_collision;
        redirect(32'h60);
        bus.imemData = BR_NEG;
        bus.exUpdate = 1; bus.exPC = 32'h60; bus.exTaken = 1; #1;
        total_cnt++;
        if (bus.prediction !== 1'b0) $display("FAIL coll_old got=%0b want=0", bus.prediction); else pass_cnt++;
        exp_q.push_back(32'h64);
        tick();
        idle();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.pc !== exp_v) $display("FAIL coll_next got=%h want=%h", bus.pc, exp_v); else pass_cnt++;
        redirect(32'h60);
        bus.imemData = BR_NEG; #1;
        total_cnt++;
        if (bus.prediction !== 1'b1) $display("FAIL coll_new got=%0b want=1", bus.prediction); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bus.stall = 1; bus.mispredict = 1; bus.correctPC = 32'h200;
        bus.exUpdate = 1; bus.exPC = 32'h60; bus.exTaken = 1; reset = 1;
        tick();
        reset = 0; idle(); bus.imemData = NOP; #1;
        total_cnt++;
        if (bus.pc !== 32'h40) $display("FAIL rstmid_pc got=%h want=00000040", bus.pc); else pass_cnt++;
        redirect(32'h60);
        bus.imemData = BR_NEG; #1;
        total_cnt++;
        if (bus.prediction !== 1'b0) $display("FAIL rstmid_pred got=%0b want=0", bus.prediction); else pass_cnt++;
    endtask

    task automatic test_wrap;
        redirect(32'hFFFF_FFFC);
        total_cnt++;
        if (bus.pcIncremented !== 32'h0) $display("FAIL wrap_pcinc got=%h want=00000000", bus.pcIncremented); else pass_cnt++;
        exp_q.push_back(32'h0);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.pc !== exp_v) $display("FAIL wrap_next got=%h want=%h", bus.pc, exp_v); else pass_cnt++;
        redirect(32'hFFFF_FFF8);
        bus.imemData = BR_ONE; #1;
        total_cnt++;
        if (bus.brBaseOffset !== 32'h0) $display("FAIL wrap_target got=%h want=00000000", bus.brBaseOffset); else pass_cnt++;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (bus.pc !== exp_v) $display("FAIL wrap_br_next got=%h want=%h", bus.pc, exp_v); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_predict_default();
        test_training();
        test_collision();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
